// File: rtl/vga_scan_driver.sv
// Raster-scan master for a 640x480@60 Hz VGA output. It queries the pixel renderers
// by position and registers their colour reply, with the sync pulses, onto the connector.
module vga_scan_driver #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst,
  output logic [9:0]  pos_x,
  output logic [9:0]  pos_y,
  input  logic [23:0] pos_data,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [3:0] DIV_LAST   = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [3:0] div_cnt;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       pix_tick;
  logic       active;
  logic       hsync_raw;
  logic       vsync_raw;
  logic       unused_pos_data;

  // Gating with rst keeps frame_start quiet while reset is held, even when CLK_DIV is 1.
  assign pix_tick = !rst && (div_cnt == DIV_LAST);

  assign active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign pos_x     = active ? h_cnt : 10'd0;
  assign pos_y     = active ? v_cnt : 10'd0;
  assign hsync_raw = !((h_cnt >= HS_START) && (h_cnt < HS_END));
  assign vsync_raw = !((v_cnt >= VS_START) && (v_cnt < VS_END));

  assign frame_start = pix_tick && (h_cnt == 10'd0) && (v_cnt == 10'd0);

  // Only the top nibble of each colour channel reaches the 12-bit connector.
  assign unused_pos_data = ^{pos_data[19:16], pos_data[11:8], pos_data[3:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= 4'd0;
    end else if (pix_tick) begin
      div_cnt <= 4'd0;
    end else begin
      div_cnt <= div_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= 10'd0;
      v_cnt <= 10'd0;
    end else if (pix_tick) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= 10'd0;
        v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  // Sync and colour go through the same register so they stay pixel-aligned at the pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      vga_r <= 4'd0;
      vga_g <= 4'd0;
      vga_b <= 4'd0;
    end else if (pix_tick) begin
      hsync <= hsync_raw;
      vsync <= vsync_raw;
      if (active) begin
        vga_r <= pos_data[23:20];
        vga_g <= pos_data[15:12];
        vga_b <= pos_data[7:4];
      end else begin
        vga_r <= 4'd0;
        vga_g <= 4'd0;
        vga_b <= 4'd0;
      end
    end
  end

endmodule
